// File: rtl/sramlike_pkg.sv
// Shared types and helpers for the SRAM-to-SRAM-like bridge.
package sramlike_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Byte enables (zero-extended to 8) to bus size; unrecognised patterns fall back to word.
  function automatic logic [1:0] wen_to_size(input logic [7:0] wen, input int strb_w);
    logic [1:0] sz;
    sz = SZ_WORD;
    for (int unsigned i = 0; i < 8; i++) begin
      if (wen == (8'h01 << i)) sz = SZ_BYTE;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen == (8'h03 << (2 * i))) sz = SZ_HALF;
    end
    if (strb_w == 8 && wen == 8'hFF) sz = SZ_DWORD;
    return sz;
  endfunction

  // True when the byte-enable pattern maps exactly onto one naturally aligned transfer.
  function automatic logic wen_is_legal(input logic [7:0] wen, input int strb_w);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (wen == (8'h01 << i)) ok = 1'b1;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (wen == (8'h03 << (2 * i))) ok = 1'b1;
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (wen == (8'h0F << (4 * i))) ok = 1'b1;
    end
    if (strb_w == 8 && wen == 8'hFF) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/sramlike_req_latch.sv
// Request capture register: holds wr/size/addr/wdata stable for the bus transaction.
module sramlike_req_latch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              next_wr,
  input  logic [1:0]        next_size,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic [DATA_W-1:0] next_wdata,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  // Capture the request when the bridge issues from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= 1'b0;
      size  <= '0;
      addr  <= '0;
      wdata <= '0;
    end else if (load) begin
      wr    <= next_wr;
      size  <= next_size;
      addr  <= next_addr;
      wdata <= next_wdata;
    end
  end

endmodule

// File: rtl/sramlike_bridge.sv
// SRAM-style core port to SRAM-like bus bridge with stall generation, flush drain
// and response hold. Optional watchdog: define SRAMLIKE_BRIDGE_TIMEOUT_EN.
module sramlike_bridge
  import sramlike_pkg::*;
#(
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int STRB_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [1:0]        cpu_rsize,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_longest_stall,
  input  logic              cpu_flush,
  output logic              cpu_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output logic              bus_err
);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("sramlike_bridge: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("sramlike_bridge: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t     state;
  logic       abort;
  logic       issue;
  logic       eff_abort;
  logic [7:0] wen_ext;
  logic [1:0] issue_size;

  // Decode the incoming request: transfer size and whether to issue this cycle.
  always_comb begin
    wen_ext             = '0;
    wen_ext[STRB_W-1:0] = cpu_wen;
    issue_size          = (|cpu_wen) ? wen_to_size(wen_ext, STRB_W) : cpu_rsize;
    issue               = (state == ST_IDLE) & cpu_en & ~cpu_flush & ~bus_err;
    eff_abort           = abort | cpu_flush;
  end

  sramlike_req_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_latch (
    .clk       (clk),
    .rst       (rst),
    .load      (issue),
    .next_wr   (|cpu_wen),
    .next_size (issue_size),
    .next_addr (cpu_addr),
    .next_wdata(cpu_wdata),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata)
  );

`ifdef SRAMLIKE_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       busy;
  logic       leaving;
  logic       tmo_hit;

  // Watchdog bookkeeping: a state exit restarts the count for the next waiting state.
  always_comb begin
    busy    = (state == ST_REQ) | (state == ST_WAIT) | (state == ST_DRAIN);
    leaving = ((state == ST_REQ)   & addr_ok) |
              ((state == ST_WAIT)  & (data_ok | cpu_flush)) |
              ((state == ST_DRAIN) & data_ok);
    tmo_hit = busy & ~leaving & (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  end
`else
  assign bus_err = 1'b0;
`endif

  // Channel stall towards the pipeline; an aborted access only stalls a live request.
  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      ST_IDLE:         cpu_stall = cpu_en & ~cpu_flush & ~bus_err;
      ST_REQ, ST_WAIT: cpu_stall = abort ? cpu_en : 1'b1;
      ST_DRAIN:        cpu_stall = cpu_en;
      default:         cpu_stall = 1'b0;
    endcase
  end

  // Bus handshake FSM with registered req and response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      abort     <= 1'b0;
      cpu_rdata <= '0;
`ifdef SRAMLIKE_BRIDGE_TIMEOUT_EN
      tmo_cnt   <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          abort <= 1'b0;
          if (issue) begin
            assert (~|cpu_wen || wen_is_legal(wen_ext, STRB_W));
            assert (|cpu_wen || DATA_W == 64 || cpu_rsize != SZ_DWORD);
            state <= ST_REQ;
            req   <= 1'b1;
          end
        end
        ST_REQ: begin
          // A flush cannot retract an offered request; remember it and drain instead.
          if (addr_ok) begin
            req   <= 1'b0;
            abort <= 1'b0;
            if (data_ok) begin
              if (eff_abort) begin
                state <= ST_IDLE;
              end else begin
                state     <= ST_HOLD;
                cpu_rdata <= rdata;
              end
            end else begin
              state <= eff_abort ? ST_DRAIN : ST_WAIT;
            end
          end else begin
            abort <= eff_abort;
          end
        end
        ST_WAIT: begin
          if (data_ok) begin
            state     <= ST_HOLD;
            cpu_rdata <= rdata;
          end else if (cpu_flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (~cpu_longest_stall | cpu_flush) state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (data_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef SRAMLIKE_BRIDGE_TIMEOUT_EN
      tmo_cnt <= (busy & ~leaving) ? tmo_cnt + 8'd1 : '0;
      if (tmo_hit) begin
        state   <= ST_IDLE;
        req     <= 1'b0;
        abort   <= 1'b0;
        bus_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sramlike_bridge.sv
// Self-checking bench for sramlike_bridge: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level expectation.
module tb_sramlike_bridge;

`ifdef SRAMLIKE_BRIDGE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = '0;
  logic [1:0]  cpu_rsize = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_longest_stall = 1'b0;
  logic        cpu_flush = 1'b0;
  logic        cpu_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        bus_err;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [31:0] last_rdata = '0;

  sramlike_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_rsize(cpu_rsize),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_longest_stall(cpu_longest_stall), .cpu_flush(cpu_flush), .cpu_stall(cpu_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, let combinational outputs settle.
  task automatic step(input logic e, input logic ls, input logic fl,
                      input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    cpu_en = e; cpu_longest_stall = ls; cpu_flush = fl;
    addr_ok = aok; data_ok = dok; rdata = rd;
    #1;
  endtask

  // fmode: 0 none, 1 flush in first WAIT cycle, 2 flush in first REQ cycle.
  task automatic run_txn(input logic [3:0] wen, input logic [1:0] sz, input logic [1:0] rsz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int a_dly, input bit same, input int d_dly, input int hold,
                         input int fmode, input int drain);
    int   stalls;
    logic e;
    logic ok;
    stalls = 0;
    @(negedge clk);
    cpu_wen = wen; cpu_rsize = rsz; cpu_addr = a; cpu_wdata = wd;
    cpu_en = 1'b1; cpu_longest_stall = 1'b1; cpu_flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = $urandom;
    #1;
    check("idle_stall", cpu_stall, 1'b1);
    check("idle_req", req, 1'b0);
    check("idle_rdata", cpu_rdata, last_rdata);
    stalls += int'(cpu_stall);
    for (int k = 0; k <= a_dly; k++) begin
      e  = (fmode == 2 && k > 0) ? 1'($urandom % 2) : 1'b1;
      ok = (k == a_dly);
      step(e, 1'b1, (fmode == 2 && k == 0), ok, ok && same, (ok && same) ? rd : $urandom);
      check("req_req", req, 1'b1);
      check("req_addr", addr, a);
      check("req_wr", wr, |wen);
      check("req_size", size, sz);
      check("req_wdata", wdata, wd);
      check("req_stall", cpu_stall, (fmode == 2 && k > 0) ? e : 1'b1);
      check("req_rdata", cpu_rdata, last_rdata);
      stalls += int'(cpu_stall);
    end
    if (fmode != 0) begin
      if (fmode == 1) begin
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);
        check("waitflush_stall", cpu_stall, 1'b1);
        check("waitflush_req", req, 1'b0);
      end
      if (!(fmode == 2 && same)) begin
        for (int j = 0; j <= drain; j++) begin
          e = 1'($urandom % 2);
          step(e, e, 1'b0, 1'b0, (j == drain), rd);
          check("drain_stall", cpu_stall, e);
          check("drain_req", req, 1'b0);
          check("drain_rdata", cpu_rdata, last_rdata);
        end
      end
      return;
    end
    if (!same) begin
      for (int j = 0; j <= d_dly; j++) begin
        step(1'b1, 1'b1, 1'b0, 1'b0, (j == d_dly), (j == d_dly) ? rd : $urandom);
        check("wait_stall", cpu_stall, 1'b1);
        check("wait_req", req, 1'b0);
        stalls += int'(cpu_stall);
      end
    end
    last_rdata = rd;
    for (int h = 0; h <= hold; h++) begin
      step(1'b1, (h < hold), 1'b0, 1'b0, 1'b0, $urandom);
      check("hold_stall", cpu_stall, 1'b0);
      check("hold_req", req, 1'b0);
      check("hold_rdata", cpu_rdata, last_rdata);
    end
    check("stall_cycles", stalls, 2 + a_dly + (same ? 0 : d_dly + 1));
  endtask

  // Idle cycles, sometimes with a request that is flushed in the same cycle.
  task automatic gap();
    int   n;
    logic e;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      e = 1'($urandom % 2);
      step(e, 1'b0, e, 1'b0, 1'b0, $urandom);
      check("gap_stall", cpu_stall, 1'b0);
      check("gap_req", req, 1'b0);
      check("gap_rdata", cpu_rdata, last_rdata);
    end
  endtask

  initial begin
    logic [3:0] wen;
    logic [1:0] sz;
    logic [1:0] rsz;
    bit         same;
    int         r;
    int         fm;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req", req, 1'b0);
    check("rst_wr", wr, 1'b0);
    check("rst_size", size, 2'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;

    // Word read: addr_ok first REQ cycle, data_ok two WAIT cycles later.
    run_txn(4'b0000, 2'd2, 2'd2, 32'hBFC00000, 32'h0, 32'h3C1DBFC1, 0, 1'b0, 1, 0, 0, 0);
    // Byte and half writes.
    run_txn(4'b0100, 2'd0, 2'd0, 32'h80001002, 32'h00AB0000, 32'h0, 0, 1'b1, 0, 0, 0, 0);
    run_txn(4'b1100, 2'd1, 2'd0, 32'h80001002, 32'hBEEF0000, 32'h0, 1, 1'b0, 0, 0, 0, 0);
    // addr_ok held off for five cycles.
    run_txn(4'b0000, 2'd2, 2'd2, 32'h10000040, 32'h5555AAAA, 32'h12345678, 5, 1'b0, 0, 0, 0, 0);
    // Global stall keeps the response in HOLD for four cycles.
    run_txn(4'b0000, 2'd1, 2'd1, 32'h10000042, 32'h0, 32'h0000CAFE, 0, 1'b1, 0, 4, 0, 0);
    // Flush in WAIT: the late read data must be discarded.
    run_txn(4'b0000, 2'd2, 2'd2, 32'h10000080, 32'h0, 32'hDEADBEEF, 0, 1'b0, 0, 0, 1, 2);
    run_txn(4'b1111, 2'd2, 2'd0, 32'h10000084, 32'hA5A5A5A5, 32'h00000011, 0, 1'b1, 0, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      rsz = 2'($urandom_range(0, 2));
      if ($urandom % 2 == 1) begin
        r = $urandom_range(0, 2);
        if (r == 0) begin
          wen = 4'b0001 << $urandom_range(0, 3);
          sz  = 2'd0;
        end else if (r == 1) begin
          wen = 4'b0011 << (2 * $urandom_range(0, 1));
          sz  = 2'd1;
        end else begin
          wen = 4'b1111;
          sz  = 2'd2;
        end
      end else begin
        wen = 4'b0000;
        sz  = rsz;
      end
      same = ($urandom % 3 == 0);
      r    = $urandom_range(0, 5);
      fm   = (r == 0 && !same) ? 1 : (r == 1) ? 2 : 0;
      run_txn(wen, sz, rsz, $urandom, $urandom, $urandom, $urandom_range(0, 4), same,
              $urandom_range(0, 3), $urandom_range(0, 3), fm, $urandom_range(0, 3));
      gap();
    end

    // Reset while waiting for data: must come back idle with cleared response.
    @(negedge clk);
    cpu_wen = 4'b0000; cpu_rsize = 2'd2; cpu_addr = 32'h20000000;
    cpu_en = 1'b1; cpu_longest_stall = 1'b1; cpu_flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1; cpu_en = 1'b0; addr_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_req", req, 1'b0);
    check("midrst_stall", cpu_stall, 1'b0);
    check("midrst_rdata", cpu_rdata, 32'h0);
    last_rdata = '0;
    run_txn(4'b0000, 2'd2, 2'd2, 32'h20000004, 32'h0, 32'h76543210, 0, 1'b1, 0, 1, 0, 0);

`ifdef SRAMLIKE_BRIDGE_TIMEOUT_EN
    // data_ok never arrives: watchdog fires after TMO cycles in WAIT.
    @(negedge clk);
    cpu_wen = 4'b0000; cpu_rsize = 2'd2; cpu_addr = 32'h30000000;
    cpu_en = 1'b1; cpu_longest_stall = 1'b1; cpu_flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int j = 0; j < TMO; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("tmo_wait_err", bus_err, 1'b0);
      check("tmo_wait_stall", cpu_stall, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("tmo_err", bus_err, 1'b1);
    check("tmo_stall", cpu_stall, 1'b0);
    check("tmo_req", req, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
